// File: rtl/mem_ctrl_arb.sv
// Multi-client DMA arbiter: grants one request at a time and splits it into
// alternating DDR command / SRAM beat handshakes of up to BEAT_BYTES each.
module mem_ctrl_arb #(
    parameter int N_CLIENTS  = 5,
    parameter int ADDR_W     = 32,
    parameter int SRAM_AW    = 19,
    parameter int LEN_W      = 8,
    parameter int BEAT_BYTES = 16,
    parameter int ARB_MODE   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CLIENTS-1:0]           req_valid,
    output logic [N_CLIENTS-1:0]           req_ready,
    input  logic [N_CLIENTS-1:0]           req_write,
    input  logic [N_CLIENTS*ADDR_W-1:0]    req_ddr_addr,
    input  logic [N_CLIENTS*SRAM_AW-1:0]   req_sram_addr,
    input  logic [N_CLIENTS*LEN_W-1:0]     req_bytes,
    output logic                           ddr_cmd_valid,
    input  logic                           ddr_cmd_ready,
    output logic                           ddr_cmd_write,
    output logic [ADDR_W-1:0]              ddr_cmd_addr,
    output logic                           beat_valid,
    input  logic                           beat_ready,
    output logic [$clog2(N_CLIENTS)-1:0]   beat_client,
    output logic [SRAM_AW-1:0]             beat_sram_addr,
    output logic [$clog2(BEAT_BYTES):0]    beat_bytes,
    output logic                           beat_last,
    output logic                           busy
);
    localparam int CW  = $clog2(N_CLIENTS);
    localparam int BBW = $clog2(BEAT_BYTES) + 1;
    localparam logic [LEN_W-1:0] BB_L = LEN_W'(BEAT_BYTES);

    typedef enum logic [1:0] {IDLE, CMD, BEAT} state_t;

    state_t              state, state_nxt;
    logic                rst_q;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       client;
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [SRAM_AW-1:0]  saddr;
    logic [LEN_W-1:0]    rem;

    logic                quiet;
    logic                take;
    logic                last;
    logic                gnt_any;
    logic [CW-1:0]       gnt;
    logic [N_CLIENTS-1:0] rot;
    logic [2*N_CLIENTS-1:0] dbl;
    int                  pos, sum;

    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [SRAM_AW-1:0]  sel_sram;
    logic [LEN_W-1:0]    sel_bytes;

    // Grants are held off during reset and the cycle after it so every output stays low.
    assign quiet = rst | rst_q;
    assign last  = (rem <= BB_L);

    // Rotate the request vector so the search always starts at bit 0.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        pos     = 0;
        sum     = 0;
        dbl     = {req_valid, req_valid};
        rot     = (ARB_MODE == 1) ? dbl[rr_ptr +: N_CLIENTS] : req_valid;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (!gnt_any && rot[i]) begin
                gnt_any = 1'b1;
                pos     = i;
            end
        end
        sum = ((ARB_MODE == 1) ? int'(rr_ptr) : 0) + pos;
        if (sum >= N_CLIENTS) sum = sum - N_CLIENTS;
        gnt = CW'(sum);
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_sram  = '0;
        sel_bytes = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (gnt == CW'(i)) begin
                sel_wr    = req_write[i];
                sel_addr  = req_ddr_addr[i*ADDR_W +: ADDR_W];
                sel_sram  = req_sram_addr[i*SRAM_AW +: SRAM_AW];
                sel_bytes = req_bytes[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any && !quiet) begin
                    take      = 1'b1;
                    state_nxt = (sel_bytes != '0) ? CMD : IDLE;
                end
            end
            CMD:  if (ddr_cmd_ready) state_nxt = BEAT;
            BEAT: if (beat_ready)    state_nxt = last ? IDLE : CMD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rst_q  <= 1'b1;
            rr_ptr <= '0;
            client <= '0;
            wr     <= 1'b0;
            addr   <= '0;
            saddr  <= '0;
            rem    <= '0;
        end else begin
            state <= state_nxt;
            rst_q <= 1'b0;
            if (take) begin
                client <= gnt;
                wr     <= sel_wr;
                addr   <= sel_addr;
                saddr  <= sel_sram;
                rem    <= sel_bytes;
                if (ARB_MODE == 1)
                    rr_ptr <= (gnt == CW'(N_CLIENTS - 1)) ? '0 : gnt + 1'b1;
            end
            if (state == BEAT && beat_ready && !last) begin
                rem   <= rem - BB_L;
                addr  <= addr + ADDR_W'(BEAT_BYTES);
                saddr <= saddr + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready      = take ? (N_CLIENTS'(1) << gnt) : '0;
        busy           = (state != IDLE) && !rst;
        ddr_cmd_valid  = (state == CMD) && !rst;
        beat_valid     = (state == BEAT) && !rst;
        ddr_cmd_write  = ddr_cmd_valid & wr;
        ddr_cmd_addr   = ddr_cmd_valid ? addr : '0;
        beat_client    = beat_valid ? client : '0;
        beat_sram_addr = beat_valid ? saddr : '0;
        beat_bytes     = beat_valid ? (last ? BBW'(rem) : BBW'(BEAT_BYTES)) : '0;
        beat_last      = beat_valid & last;
    end
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Random-stimulus bench: a round-robin and a fixed-priority instance share inputs and
// are checked against a transaction-level model of grants and per-beat payloads.
module tb_mem_ctrl_arb;
    localparam int N = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid, req_write;
    logic [N*32-1:0]      req_ddr_addr;
    logic [N*19-1:0]      req_sram_addr;
    logic [N*8-1:0]       req_bytes;
    logic                 cmd_rdy, beat_rdy;

    logic [1:0][N-1:0]    rdy;
    logic [1:0]           cv, cw, bv, bl, bsy;
    logic [1:0][31:0]     ca;
    logic [1:0][2:0]      bc;
    logic [1:0][18:0]     bs;
    logic [1:0][4:0]      bb;

    int checks = 0, errors = 0;

    // Per-unit model: phase 0 idle, 1 awaiting command, 2 awaiting beat.
    int          ph[2], rr[2], kb[2], tot[2], cl[2], ngrant[2];
    logic [31:0] sa[2];
    logic [18:0] ss[2];
    logic        wm[2];
    bit          quiet = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl_arb #(.ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_write(req_write), .req_ddr_addr(req_ddr_addr), .req_sram_addr(req_sram_addr),
        .req_bytes(req_bytes), .ddr_cmd_valid(cv[0]), .ddr_cmd_ready(cmd_rdy),
        .ddr_cmd_write(cw[0]), .ddr_cmd_addr(ca[0]), .beat_valid(bv[0]),
        .beat_ready(beat_rdy), .beat_client(bc[0]), .beat_sram_addr(bs[0]),
        .beat_bytes(bb[0]), .beat_last(bl[0]), .busy(bsy[0]));

    mem_ctrl_arb #(.ARB_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_ddr_addr(req_ddr_addr), .req_sram_addr(req_sram_addr),
        .req_bytes(req_bytes), .ddr_cmd_valid(cv[1]), .ddr_cmd_ready(cmd_rdy),
        .ddr_cmd_write(cw[1]), .ddr_cmd_addr(ca[1]), .beat_valid(bv[1]),
        .beat_ready(beat_rdy), .beat_client(bc[1]), .beat_sram_addr(bs[1]),
        .beat_bytes(bb[1]), .beat_last(bl[1]), .busy(bsy[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int arb(input logic [N-1:0] v, input int ptr, input bit rrm);
        int p = rrm ? ptr : 0;
        for (int i = 0; i < N; i++) begin
            int c = (p + i) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Inputs only change just after posedge, so what is seen here is what the next edge samples.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            string       t;
            int          g, rem, eb;
            logic [N-1:0] er;
            logic [31:0] ea;
            logic [18:0] es;
            logic        el;
            t = (u == 0) ? "rr" : "fix";
            if (rst || quiet) begin
                chk({t, "_rst_ctl"}, 64'({rdy[u], bsy[u], cv[u], cw[u], bv[u], bl[u]}), 64'd0);
                chk({t, "_rst_pay"}, 64'({ca[u], bc[u], bs[u], bb[u]}), 64'd0);
                if (rst) begin ph[u] = 0; rr[u] = 0; end
            end else if (ph[u] == 0) begin
                g  = arb(req_valid, rr[u], u == 0);
                er = (g < 0) ? '0 : (N'(1) << g);
                chk({t, "_idle_ctl"}, 64'({rdy[u], bsy[u], cv[u], bv[u]}), 64'({er, 3'b000}));
                if (g >= 0) begin
                    ngrant[u]++;
                    if (u == 0) rr[u] = (g + 1) % N;
                    tot[u] = int'(req_bytes[g*8 +: 8]);
                    if (tot[u] > 0) begin
                        sa[u] = req_ddr_addr[g*32 +: 32];
                        ss[u] = req_sram_addr[g*19 +: 19];
                        wm[u] = req_write[g];
                        cl[u] = g;
                        kb[u] = 0;
                        ph[u] = 1;
                    end
                end
            end else begin
                rem = tot[u] - 16 * kb[u];
                eb  = (rem > 16) ? 16 : rem;
                el  = (rem <= 16);
                ea  = sa[u] + 32'(16 * kb[u]);
                es  = ss[u] + 19'(kb[u]);
                if (ph[u] == 1) begin
                    chk({t, "_cmd_ctl"}, 64'({rdy[u], bsy[u], cv[u], bv[u]}), 64'({5'b0, 3'b110}));
                    chk({t, "_cmd_pay"}, 64'({cw[u], ca[u]}), 64'({wm[u], ea}));
                    if (cmd_rdy) ph[u] = 2;
                end else begin
                    chk({t, "_beat_ctl"}, 64'({rdy[u], bsy[u], cv[u], bv[u]}), 64'({5'b0, 3'b101}));
                    chk({t, "_beat_pay"}, 64'({bc[u], bs[u], bb[u], bl[u]}),
                        64'({3'(cl[u]), es, 5'(eb), el}));
                    if (beat_rdy) begin
                        if (el) ph[u] = 0;
                        else begin kb[u]++; ph[u] = 1; end
                    end
                end
            end
        end
        quiet = rst;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [31:0] a, input logic [18:0] s,
                           input logic [7:0] b, input logic w);
        req_ddr_addr[c*32 +: 32] = a;
        req_sram_addr[c*19 +: 19] = s;
        req_bytes[c*8 +: 8] = b;
        req_write[c] = w;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            ph[u] = 0; rr[u] = 0; kb[u] = 0; tot[u] = 0; cl[u] = 0; ngrant[u] = 0;
            sa[u] = '0; ss[u] = '0; wm[u] = 1'b0;
        end
        rst = 1'b1; req_valid = '0; req_write = '0; req_ddr_addr = '0;
        req_sram_addr = '0; req_bytes = '0; cmd_rdy = 1'b0; beat_rdy = 1'b0;
        step(3);
        rst = 1'b0;

        // Clients 0,2,4 streaming single-beat requests, sinks always ready.
        for (int c = 0; c < N; c++) set_req(c, $urandom, 19'($urandom), 8'd16, 1'($urandom));
        req_valid = 5'b10101; cmd_rdy = 1'b1; beat_rdy = 1'b1;
        step(40);

        // Three-beat request with a short tail beat, random backpressure.
        req_valid = 5'b00100;
        set_req(2, 32'h1000, 19'h10, 8'd40, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cmd_rdy = 1'($urandom); beat_rdy = 1'($urandom);
            step(1);
        end

        // Address wrap on both sides with readies low three cycles out of four.
        req_valid = 5'b01000;
        set_req(3, 32'hFFFF_FFF0, 19'h7FFFF, 8'd32, 1'b0);
        for (int i = 0; i < 48; i++) begin
            cmd_rdy = (i % 4 == 3); beat_rdy = (i % 4 == 3);
            step(1);
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            req_valid = N'($urandom) & N'($urandom | $urandom);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    logic [7:0]  b;
                    logic [31:0] a;
                    logic [18:0] s;
                    case ($urandom_range(0, 5))
                        0: b = 8'd0;
                        1: b = 8'd16;
                        2: b = 8'd40;
                        3: b = 8'd48;
                        default: b = 8'($urandom_range(1, 255));
                    endcase
                    a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : $urandom;
                    s = ($urandom_range(0, 5) == 0) ? 19'h7FFFF - 19'($urandom_range(0, 3)) : 19'($urandom);
                    set_req(c, a, s, b, 1'($urandom));
                end
            end
            cmd_rdy  = ($urandom_range(0, 9) < 6);
            beat_rdy = ($urandom_range(0, 9) < 6);
            step(1);
        end

        // Drain, then reset during the second beat of a 48-byte request.
        rst = 1'b0; req_valid = '0; cmd_rdy = 1'b1; beat_rdy = 1'b1;
        step(40);
        set_req(1, 32'h2000, 19'h20, 8'd48, 1'b1);
        req_valid = 5'b00010;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req_valid = 5'b00011;
        step(20);

        chk("rr_grants_seen", 64'(ngrant[0] > 100), 64'd1);
        chk("fix_grants_seen", 64'(ngrant[1] > 100), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
